// File: rtl/aes_host_master.sv
// -----------------------------------------------------------------------------
// aes_host_master
//   Bus-side initiator for the AES host port. One accepted start writes a
//   128-bit key and a 128-bit message as four 32-bit words each, waits for the
//   core's CS completion flag, reads four ciphertext words back and presents
//   the reassembled 128-bit result.
//
//   The 128-bit vectors are declared [127:0]. Bit 0 of the host-port numbering
//   (bits 0:31 = first word) is bit 127 here, so word k is [127-32k -: 32].
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   start      one-cycle request, only looked at in IDLE
//   key_in     128-bit key, most significant word sent first
//   msg_in     128-bit plaintext, most significant word sent first
//   busy       high while a transaction is in flight
//   done       one-cycle pulse, result valid
//   error      one-cycle pulse, CS never arrived within TIMEOUT_CYCLES
//   result     ciphertext, first word read lands in the top 32 bits
//   bus_wdata  word to the port shift registers
//   bus_rdata  word from the port, READ_LATENCY cycles after a read strobe
//   RW         1 = write, 0 = read
//   adress     write target: 1 = key register, 0 = message register
//   initiate   transfer strobe
//   CS         core-complete flag
//   state_dbg  current FSM state encoding
//
// Port handshake: every cycle with initiate=1 is exactly one transfer; there is
// no back-pressure. With RW=1 bus_wdata is shifted into the register selected
// by adress. With RW=0 one ciphertext word is popped and is valid on bus_rdata
// READ_LATENCY cycles later. With initiate=0, RW, adress and bus_wdata are 0.
// -----------------------------------------------------------------------------
module aes_host_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned READ_LATENCY   = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic [127:0] msg_in,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [127:0] result,
  output logic [31:0]  bus_wdata,
  input  logic [31:0]  bus_rdata,
  output logic         RW,
  output logic         adress,
  output logic         initiate,
  input  logic         CS,
  output logic [2:0]   state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_KEY  = 3'd1,
    S_WR_MSG  = 3'd2,
    S_WAIT_CS = 3'd3,
    S_RD      = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [15:0] TMR_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [127:0]            key_q, msg_q;
  logic [1:0]              wcnt_q;
  logic [15:0]             tmr_q;
  logic [2:0]              rd_cnt_q;
  logic [1:0]              cap_cnt_q;
  logic [READ_LATENCY-1:0] rd_pipe_q;
  logic                    error_q;

  logic strobe;
  logic cap_en;

  function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] idx);
    case (idx)
      2'd0:    word_of = v[127:96];
      2'd1:    word_of = v[95:64];
      2'd2:    word_of = v[63:32];
      default: word_of = v[31:0];
    endcase
  endfunction

  // Read strobes run until four have been issued; the delay pipe marks the
  // cycle in which each strobe's word is on bus_rdata, so strobes and captures
  // overlap freely when READ_LATENCY < 4.
  assign strobe = (state_q == S_RD) && (rd_cnt_q != 3'd4);
  assign cap_en = rd_pipe_q[READ_LATENCY-1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_WR_KEY;
      S_WR_KEY:  if (wcnt_q == 2'd3) state_d = S_WR_MSG;
      S_WR_MSG:  if (wcnt_q == 2'd3) state_d = S_WAIT_CS;
      // CS is checked first so a completion on the limit cycle still reads.
      S_WAIT_CS: begin
        if (CS)                    state_d = S_RD;
        else if (tmr_q == TMR_LAST) state_d = S_IDLE;
      end
      S_RD:      if (cap_en && (cap_cnt_q == 2'd3)) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Bus outputs decode straight from state so reset drops them immediately.
  always_comb begin
    initiate  = 1'b0;
    RW        = 1'b0;
    adress    = 1'b0;
    bus_wdata = 32'd0;
    case (state_q)
      S_WR_KEY: begin
        initiate  = 1'b1;
        RW        = 1'b1;
        adress    = 1'b1;
        bus_wdata = word_of(key_q, wcnt_q);
      end
      S_WR_MSG: begin
        initiate  = 1'b1;
        RW        = 1'b1;
        bus_wdata = word_of(msg_q, wcnt_q);
      end
      S_RD:     initiate = strobe;
      default:  ;
    endcase
  end

  assign busy      = (state_q == S_WR_KEY) || (state_q == S_WR_MSG) ||
                     (state_q == S_WAIT_CS) || (state_q == S_RD);
  assign done      = (state_q == S_DONE);
  assign error     = error_q;
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      key_q     <= '0;
      msg_q     <= '0;
      wcnt_q    <= '0;
      tmr_q     <= '0;
      rd_cnt_q  <= '0;
      cap_cnt_q <= '0;
      rd_pipe_q <= '0;
      error_q   <= 1'b0;
      result    <= '0;
    end else begin
      state_q   <= state_d;
      error_q   <= (state_q == S_WAIT_CS) && !CS && (tmr_q == TMR_LAST);
      rd_pipe_q <= (rd_pipe_q << 1) | READ_LATENCY'(strobe);

      if ((state_q == S_IDLE) && start) begin
        key_q <= key_in;
        msg_q <= msg_in;
      end

      if ((state_q == S_WR_KEY) || (state_q == S_WR_MSG)) wcnt_q <= wcnt_q + 2'd1;
      else                                                  wcnt_q <= '0;

      if (state_q == S_WAIT_CS) tmr_q <= tmr_q + 16'd1;
      else                      tmr_q <= '0;

      if (state_q == S_RD) begin
        if (strobe) rd_cnt_q <= rd_cnt_q + 3'd1;
        if (cap_en) begin
          cap_cnt_q <= cap_cnt_q + 2'd1;
          case (cap_cnt_q)
            2'd0:    result[127:96] <= bus_rdata;
            2'd1:    result[95:64]  <= bus_rdata;
            2'd2:    result[63:32]  <= bus_rdata;
            default: result[31:0]   <= bus_rdata;
          endcase
        end
      end else begin
        rd_cnt_q  <= '0;
        cap_cnt_q <= '0;
      end
    end
  end

endmodule
